pixel_read_control: RTL and testbench

Read-side counterpart of the coprocessor's byte-write path into packed pixel memory. The block takes an 18-bit byte address, issues a word read on the 16-bit word address bus of the 32-bit-wide pixel RAM, waits for the RAM read latency, and returns the addressed byte with a level-based `read_request`/`done` handshake. It sits between the filter datapath and the same pixel RAM port the write path uses. An optional one-word cache lets consecutive reads of the same word skip the RAM access.

---
 rtl/pixel_mem_pkg.sv | 18 +
 rtl/byte_lane_select.sv | 17 +
 rtl/pixel_read_control.sv | 162 ++++++++++++++++
 tb/tb_pixel_read_control.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_mem_pkg.sv
// Shared types and widths for the packed pixel memory read/write paths.
// Word address = byte address [17:2]; byte lane = byte address [1:0].
package pixel_mem_pkg;

   localparam int PIX_ADDR_W     = 18;
   localparam int WORD_ADDR_W    = 16;
   localparam int WORD_W         = 32;
   localparam int PIX_W          = 8;
   localparam int RD_LATENCY_DEF = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CAPTURE,
      DONE
   } rd_state_e;

endpackage

// File: rtl/byte_lane_select.sv
// Picks one byte out of a 32-bit pixel word by offset and lane order.
// swap=1 reverses lanes, so offset 0 maps to the top byte.
module byte_lane_select
   import pixel_mem_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [1:0]        offset,
   input  logic              swap,
   output logic [PIX_W-1:0]  sel_byte
);

   logic [1:0] lane;

   assign lane     = swap ? ~offset : offset;
   assign sel_byte = word[{lane, 3'b000} +: PIX_W];

endmodule

// File: rtl/pixel_read_control.sv
// Byte read from packed pixel RAM with level request/done handshake.
// Optional one-word read cache: define PIXEL_READ_CACHE_EN.
module pixel_read_control
   import pixel_mem_pkg::*;
#(
   parameter int RD_LATENCY = RD_LATENCY_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   read_request,
   input  logic [PIX_ADDR_W-1:0]  address,
   input  logic                   byte_swap,
   input  logic                   invalidate,
   input  logic [WORD_W-1:0]      ram_data,
   output logic [WORD_ADDR_W-1:0] addr,
   output logic [PIX_W-1:0]       pixel_out,
   output logic                   done
);

   localparam logic [2:0] LAST = 3'(RD_LATENCY - 1);

   rd_state_e              state_q, state_n;
   logic [2:0]             cnt_q, cnt_n;
   logic [1:0]             off_q, off_n;
   logic                   swap_q, swap_n;
   logic [WORD_W-1:0]      word_q, word_n;
   logic [WORD_ADDR_W-1:0] addr_n;
   logic [PIX_W-1:0]       pix_n;
   logic                   done_n;
   logic                   hit;
   logic [PIX_W-1:0]       lane_byte;
   logic [WORD_ADDR_W-1:0] req_word;

   assign req_word = address[PIX_ADDR_W-1:2];

   // The word buffer doubles as the cached word; done/pixel_out
   // are registered from the DONE state one edge after entry.
   byte_lane_select u_sel (
      .word     (word_q),
      .offset   (off_q),
      .swap     (swap_q),
      .sel_byte (lane_byte)
   );

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      off_n   = off_q;
      swap_n  = swap_q;
      word_n  = word_q;
      addr_n  = addr;
      pix_n   = pixel_out;
      done_n  = done;
      unique case (state_q)
         IDLE: begin
            cnt_n = 3'd0;
            if (read_request) begin
               addr_n  = req_word;
               off_n   = address[1:0];
               swap_n  = byte_swap;
               state_n = hit ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (!read_request) begin
               cnt_n   = 3'd0;
               state_n = IDLE;
            end else if (cnt_q == LAST) begin
               cnt_n   = 3'd0;
               state_n = CAPTURE;
            end else begin
               cnt_n = cnt_q + 3'd1;
            end
         end
         CAPTURE: begin
            if (!read_request) begin
               state_n = IDLE;
            end else begin
               word_n  = ram_data;
               state_n = DONE;
            end
         end
         DONE: begin
            if (read_request) begin
               done_n = 1'b1;
               pix_n  = lane_byte;
            end else begin
               done_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         off_q     <= 2'd0;
         swap_q    <= 1'b0;
         word_q    <= '0;
         addr      <= '0;
         pixel_out <= '0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         off_q     <= off_n;
         swap_q    <= swap_n;
         word_q    <= word_n;
         addr      <= addr_n;
         pixel_out <= pix_n;
         done      <= done_n;
      end
   end

`ifdef PIXEL_READ_CACHE_EN
   logic                   valid_q, valid_n;
   logic                   poison_q, poison_n;
   logic [WORD_ADDR_W-1:0] tag_q, tag_n;

   assign hit = valid_q && !invalidate && (tag_q == req_word);

   // A write landing mid-read may leave stale data in flight.
   always_comb begin
      valid_n  = valid_q;
      tag_n    = tag_q;
      poison_n = poison_q;
      if (state_q == CAPTURE && read_request
          && !poison_q && !invalidate) begin
         valid_n = 1'b1;
         tag_n   = addr;
      end
      if (invalidate) begin
         valid_n = 1'b0;
         if (state_q == WAIT || state_q == CAPTURE)
            poison_n = 1'b1;
      end
      if (state_n == IDLE)
         poison_n = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         poison_q <= 1'b0;
         tag_q    <= '0;
      end else begin
         valid_q  <= valid_n;
         poison_q <= poison_n;
         tag_q    <= tag_n;
      end
   end
`else
   logic unused_inv;

   assign hit        = 1'b0;
   assign unused_inv = invalidate;
`endif

endmodule

// File: tb/tb_pixel_read_control.sv
// Randomized scoreboard bench for pixel_read_control.
// Follows PIXEL_READ_CACHE_EN to pick the cache reference model.
module tb_pixel_read_control;

   localparam int L = 2;

`ifdef PIXEL_READ_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        read_request = 1'b0;
   logic [17:0] address = '0;
   logic        byte_swap = 1'b0;
   logic        invalidate = 1'b0;
   logic [31:0] ram_data;
   logic [15:0] addr;
   logic [7:0]  pixel_out;
   logic        done;

   pixel_read_control #(.RD_LATENCY(L)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .read_request (read_request),
      .address      (address),
      .byte_swap    (byte_swap),
      .invalidate   (invalidate),
      .ram_data     (ram_data),
      .addr         (addr),
      .pixel_out    (pixel_out),
      .done         (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [0:65535];
   logic [31:0] pipe [0:L-1];

   always @(posedge clk) begin
      pipe[0] <= mem[addr];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_data = pipe[L-1];

   typedef struct {
      logic [7:0]  pix;
      int          lat;
      int          t;
      logic [15:0] w;
   } exp_t;

   exp_t sbq[$];
   int total = 0;
   int bad = 0;

   bit          cvalid = 1'b0;
   logic [15:0] ctag = '0;
   logic [31:0] cword = '0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] lane_of(input logic [31:0] wd,
                                          input logic [1:0] off,
                                          input logic sw);
      int n;
      n = sw ? 3 - int'(off) : int'(off);
      return 8'((wd >> (8 * n)) & 32'hFF);
   endfunction

   logic done_q = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done && !done_q) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done act=1 exp=0 t=%0t", $time);
         end else begin
            e = sbq.pop_front();
            chk("pixel", 32'(pixel_out), 32'(e.pix));
            chk("latency", cyc - e.t, e.lat);
            chk("addr", 32'(addr), 32'(e.w));
         end
      end
      done_q = done;
   end

   // inv_mode: 0 none, 1 with the request sample, 2 one edge later
   task automatic txn(input logic [17:0] a, input logic sw,
                      input int inv_mode, input int abort_in,
                      input int hold, input bit do_wr);
      logic [15:0] w;
      logic [31:0] ew, nv;
      bit          hit, seen;
      int          abort_at, k;
      exp_t        e;
      w        = a[17:2];
      abort_at = abort_in;
      hit      = CACHE && cvalid && ctag == w && inv_mode != 1;
      if (hit) abort_at = 0;
      nv    = $urandom;
      ew    = hit ? cword : ((inv_mode != 0 && do_wr) ? nv : mem[w]);
      e.pix = lane_of(ew, a[1:0], sw);
      e.lat = hit ? 1 : L + 2;
      e.w   = w;
      @(negedge clk);
      address      = a;
      byte_swap    = sw;
      read_request = 1'b1;
      e.t          = cyc + 1;
      if (inv_mode == 1) begin
         invalidate = 1'b1;
         if (do_wr) mem[w] = nv;
      end
      if (abort_at == 0) sbq.push_back(e);
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 40) begin
         k++;
         @(negedge clk);
         invalidate = 1'b0;
         if (inv_mode == 2 && k == 1) begin
            invalidate = 1'b1;
            if (do_wr) mem[w] = nv;
         end
         if (abort_at != 0 && k == abort_at) begin
            read_request = 1'b0;
            seen = 1'b1;
         end else if (done) begin
            seen = 1'b1;
         end
      end
      if (abort_at != 0) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            invalidate = 1'b0;
            chk("abort_done", 32'(done), 32'd0);
         end
      end else if (!seen) begin
         total++;
         bad++;
         $display("FAIL timeout act=0 exp=1 t=%0t", $time);
         if (sbq.size() > 0) void'(sbq.pop_back());
         read_request = 1'b0;
         invalidate   = 1'b0;
         @(negedge clk);
      end else begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_pix", 32'(pixel_out), 32'(e.pix));
            chk("hold_addr", 32'(addr), 32'(w));
         end
         read_request = 1'b0;
         @(negedge clk);
         chk("done_fall", 32'(done), 32'd0);
      end
      if (inv_mode != 0) cvalid = 1'b0;
      if (!hit && abort_at == 0 && inv_mode != 2) begin
         cvalid = 1'b1;
         ctag   = w;
         cword  = ew;
      end
   endtask

   task automatic reset_mid_wait();
      @(negedge clk);
      address      = 18'h00402;
      byte_swap    = 1'b0;
      read_request = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_pix", 32'(pixel_out), 32'd0);
      @(negedge clk);
      read_request = 1'b0;
      rst_n        = 1'b1;
      cvalid       = 1'b0;
      ctag         = '0;
      cword        = '0;
   endtask

   logic [15:0] wset [5];

   initial begin
      logic [15:0] w;
      for (int i = 0; i < 65536; i++) mem[i] = $urandom;
      mem[16'h0100] = 32'hDDCCBBAA;
      wset[0] = 16'h0100;
      wset[1] = 16'h0101;
      wset[2] = 16'h3FFF;
      wset[3] = 16'hFFFF;
      wset[4] = 16'h0000;
      #2 rst_n = 1'b0;
      #3;
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_addr", 32'(addr), 32'd0);
      chk("reset_pix", 32'(pixel_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      txn(18'h00402, 1'b0, 0, 0, 0, 1'b0);
      txn(18'h00402, 1'b1, 0, 0, 0, 1'b0);
      txn(18'h00402, 1'b0, 1, 2, 0, 1'b0);
      txn(18'h00402, 1'b0, 0, 0, 0, 1'b0);
      txn(18'h00400, 1'b0, 0, 0, 0, 1'b0);
      txn(18'h00403, 1'b0, 0, 0, 0, 1'b0);
      txn(18'h00404, 1'b0, 2, 0, 0, 1'b1);
      txn(18'h00404, 1'b0, 0, 0, 0, 1'b0);
      txn(18'h00405, 1'b0, 1, 0, 0, 1'b1);
      txn(18'h00406, 1'b1, 0, 0, 10, 1'b0);
      reset_mid_wait();
      txn(18'h00402, 1'b0, 0, 0, 1, 1'b0);

      for (int n = 0; n < 200; n++) begin
         int im, ab;
         w  = wset[$urandom_range(0, 4)];
         im = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, L + 1) : 0;
         txn({w, 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)),
             im, ab, $urandom_range(0, 3), 1'b1);
      end

      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
